// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined multiply-accumulate engine.
// Build option: define MAC_SATURATE_EN to clamp each accumulation step on
// overflow instead of wrapping (see mac_acc_step).
package mac_pkg;

  // Default geometry of the engine
  localparam int MAC_WIDTH_A_DEF   = 5;
  localparam int MAC_WIDTH_B_DEF   = 7;
  localparam int MAC_ACC_WIDTH_DEF = 16;
  localparam int MAC_SIGNED_DEF    = 0;

  // Layout of the P-stage payload at the default geometry. The top module
  // carries the same fields, in the same order, sized to its own parameters.
  typedef struct packed {
    logic [MAC_ACC_WIDTH_DEF-1:0] prod;
    logic [MAC_ACC_WIDTH_DEF-1:0] c;
    logic                         first;
    logic                         last;
  } mac_p_stage_t;

  // Overflow of one addition step.
  // Unsigned: carry out of the accumulator width.
  // Signed: both addends share a sign and the wrapped sum has the other sign.
  function automatic logic mac_step_ovf(
    input logic is_signed,
    input logic a_msb,
    input logic b_msb,
    input logic sum_msb,
    input logic carry
  );
    logic r_ovf;
    if (is_signed) begin
      r_ovf = (a_msb == b_msb) && (sum_msb != a_msb);
    end else begin
      r_ovf = carry;
    end
    return r_ovf;
  endfunction

endpackage

// File: rtl/mac_acc_step.sv
// One accumulation step: i_a + i_b at ACC_WIDTH bits with overflow detect.
// With MAC_SATURATE_EN defined the sum clamps on overflow; otherwise it wraps.
module mac_acc_step
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = MAC_ACC_WIDTH_DEF,
  parameter int SIGNED    = MAC_SIGNED_DEF
) (
  input  logic [ACC_WIDTH-1:0] i_a,
  input  logic [ACC_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  logic [ACC_WIDTH:0]   w_full;
  logic [ACC_WIDTH-1:0] w_wrap;
  logic                 w_ovf;

  // Raw sum with carry, and the overflow decision for this step
  always_comb begin
    w_full = {1'b0, i_a} + {1'b0, i_b};
    w_wrap = w_full[ACC_WIDTH-1:0];
    w_ovf  = mac_step_ovf(SIGNED != 0, i_a[ACC_WIDTH-1], i_b[ACC_WIDTH-1],
                          w_wrap[ACC_WIDTH-1], w_full[ACC_WIDTH]);
  end

`ifdef MAC_SATURATE_EN
  // Clamp on overflow; in signed mode both addends share the sign that picks the rail
  always_comb begin
    o_sum = w_wrap;
    if (w_ovf) begin
      if (SIGNED != 0) begin
        if (i_a[ACC_WIDTH-1]) begin
          o_sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
          o_sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
      end else begin
        o_sum = {ACC_WIDTH{1'b1}};
      end
    end else begin
      o_sum = w_wrap;
    end
  end
`else
  // Wrap-around result modulo 2^ACC_WIDTH
  always_comb begin
    o_sum = w_wrap;
  end
`endif

  assign o_ovf = w_ovf;

endmodule

// File: rtl/pipelined_mac.sv
// Pipelined multiply-accumulate: frame result = C + sum(A*B).
// Stage P registers the product and frame controls, stage ACC accumulates and
// emits the result on the last beat. A full output register that downstream
// does not take freezes both stages (in_ready drops).
// Build option: MAC_SATURATE_EN selects clamping accumulation (mac_acc_step).
module pipelined_mac
  import mac_pkg::*;
#(
  parameter int WIDTH_A   = MAC_WIDTH_A_DEF,
  parameter int WIDTH_B   = MAC_WIDTH_B_DEF,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH_DEF,  // must be >= WIDTH_A+WIDTH_B
  parameter int SIGNED    = MAC_SIGNED_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [WIDTH_A-1:0]   A,
  input  logic [WIDTH_B-1:0]   B,
  input  logic [ACC_WIDTH-1:0] C,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 out_ovf
);

  localparam int PW = WIDTH_A + WIDTH_B;

  // P-stage payload at this instance's accumulator width
  typedef struct packed {
    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] c;
    logic                 first;
    logic                 last;
  } p_stage_t;

  logic [PW-1:0]        w_a_ext;
  logic [PW-1:0]        w_b_ext;
  logic [PW-1:0]        w_prod_n;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic                 w_stall;
  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_step_ovf;
  logic                 w_ovf_total;

  p_stage_t             r_p;
  logic                 r_p_valid;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf_acc;
  logic [ACC_WIDTH-1:0] r_out;
  logic                 r_out_ovf;
  logic                 r_out_valid;

  // A held result that downstream refuses freezes the whole pipeline
  assign w_stall  = r_out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_accept = in_valid && in_ready;

  generate
    if (SIGNED != 0) begin : g_signed
      // Two's-complement product at PW bits, sign-extended to the accumulator
      always_comb begin
        w_a_ext    = {{(PW-WIDTH_A){A[WIDTH_A-1]}}, A};
        w_b_ext    = {{(PW-WIDTH_B){B[WIDTH_B-1]}}, B};
        w_prod_n   = w_a_ext * w_b_ext;
        w_prod_ext = ACC_WIDTH'($signed(w_prod_n));
      end
    end else begin : g_unsigned
      // Unsigned product at PW bits, zero-extended to the accumulator
      always_comb begin
        w_a_ext    = {{(PW-WIDTH_A){1'b0}}, A};
        w_b_ext    = {{(PW-WIDTH_B){1'b0}}, B};
        w_prod_n   = w_a_ext * w_b_ext;
        w_prod_ext = ACC_WIDTH'(w_prod_n);
      end
    end
  endgenerate

  // Stage P: capture product, bias and frame markers of each accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p.prod  <= {ACC_WIDTH{1'b0}};
      r_p.c     <= {ACC_WIDTH{1'b0}};
      r_p.first <= 1'b0;
      r_p.last  <= 1'b0;
      r_p_valid <= 1'b0;
    end else if (!w_stall) begin
      r_p_valid <= w_accept;
      if (w_accept) begin
        r_p.prod  <= w_prod_ext;
        r_p.c     <= C;
        r_p.first <= in_first;
        r_p.last  <= in_last;
      end
    end
  end

  // Frame start restarts from the bias and drops any partial overflow history
  always_comb begin
    w_base      = r_p.first ? r_p.c : r_acc;
    w_ovf_total = (r_p.first ? 1'b0 : r_ovf_acc) | w_step_ovf;
  end

  mac_acc_step #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED)
  ) u_step (
    .i_a   (w_base),
    .i_b   (r_p.prod),
    .o_sum (w_sum),
    .o_ovf (w_step_ovf)
  );

  // Stage ACC: accumulate, and on the last beat publish the result and rearm
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= {ACC_WIDTH{1'b0}};
      r_ovf_acc   <= 1'b0;
      r_out       <= {ACC_WIDTH{1'b0}};
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      // Not stalled means any held result is being taken this cycle
      r_out_valid <= r_p_valid && r_p.last;
      if (r_p_valid) begin
        if (r_p.last) begin
          r_acc     <= {ACC_WIDTH{1'b0}};
          r_ovf_acc <= 1'b0;
          r_out     <= w_sum;
          r_out_ovf <= w_ovf_total;
        end else begin
          r_acc     <= w_sum;
          r_ovf_acc <= w_ovf_total;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_pipelined_mac.sv
// Self-checking bench for pipelined_mac. Three instances share one stimulus
// stream: default (16-bit unsigned), 12-bit unsigned, and 16-bit signed.
// An arithmetic frame model predicts each result at accept time; per-instance
// monitors pop and compare whenever a result is handed over.
module tb_pipelined_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  a_in = 5'd0;
  logic [6:0]  b_in = 7'd0;
  logic [15:0] c_in = 16'd0;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic [15:0] o0, o2;
  logic [11:0] o1;

  always #5 clk = ~clk;

  pipelined_mac #(.WIDTH_A(5), .WIDTH_B(7), .ACC_WIDTH(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_first(in_first), .in_last(in_last), .A(a_in), .B(b_in), .C(c_in),
    .out_valid(ov0), .out_ready(out_ready), .out(o0), .out_ovf(of0));

  pipelined_mac #(.WIDTH_A(5), .WIDTH_B(7), .ACC_WIDTH(12), .SIGNED(0)) u_w12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_first(in_first), .in_last(in_last), .A(a_in), .B(b_in), .C(c_in[11:0]),
    .out_valid(ov1), .out_ready(out_ready), .out(o1), .out_ovf(of1));

  pipelined_mac #(.WIDTH_A(5), .WIDTH_B(7), .ACC_WIDTH(16), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .in_first(in_first), .in_last(in_last), .A(a_in), .B(b_in), .C(c_in),
    .out_valid(ov2), .out_ready(out_ready), .out(o2), .out_ovf(of2));

  typedef struct {
    logic [15:0] val;
    bit          ovf;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];
  int     errors = 0;
  int     checks = 0;
  longint m_acc[3];
  bit     m_ovf[3];
  bit     ready_rand = 1'b0;

  function automatic int cfg_w(int k);
    return (k == 1) ? 12 : 16;
  endfunction

  function automatic bit cfg_s(int k);
    return (k == 2);
  endfunction

  task automatic check(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Frame model: plain integer arithmetic, range test, then wrap or clamp
  function automatic void model_beat(bit f, bit l, logic [4:0] a, logic [6:0] b, logic [15:0] c);
    for (int k = 0; k < 3; k++) begin
      int     w    = cfg_w(k);
      bit     s    = cfg_s(k);
      longint full = longint'(1) << w;
      longint av, bv, cv, sum, lo, hi;
      bit     ov, flag;
      exp_t   e;
      av = longint'(a);
      bv = longint'(b);
      cv = longint'(c) & (full - 1);
      if (s) begin
        if (a[4]) av = av - 32;
        if (b[6]) bv = bv - 128;
        if (cv >= full / 2) cv = cv - full;
      end
      lo  = s ? -(full / 2) : 0;
      hi  = s ? (full / 2) - 1 : full - 1;
      sum = (f ? cv : m_acc[k]) + av * bv;
      ov  = (sum < lo) || (sum > hi);
`ifdef MAC_SATURATE_EN
      if (sum > hi) sum = hi;
      if (sum < lo) sum = lo;
`else
      if (sum > hi) sum = sum - full;
      if (sum < lo) sum = sum + full;
`endif
      flag = (f ? 1'b0 : m_ovf[k]) | ov;
      if (l) begin
        e.val = 16'(sum & (full - 1));
        e.ovf = flag;
        case (k)
          0: q0.push_back(e);
          1: q1.push_back(e);
          2: q2.push_back(e);
          default: ;
        endcase
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end else begin
        m_acc[k] = sum;
        m_ovf[k] = flag;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endfunction

  // Compare one instance's handed-over result with the head of its queue
  task automatic mon_one(int k, logic v, logic [15:0] got, logic gotovf, logic rdy);
    exp_t e;
    bit   have = 1'b0;
    check($sformatf("in_ready_%0d", k), rdy, !(v && !out_ready));
    if (v && out_ready) begin
      case (k)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        default: ;
      endcase
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_%0d: got out=%0d with no result pending, required none", k, got);
      end else begin
        check($sformatf("out_%0d", k), got, e.val);
        check($sformatf("out_ovf_%0d", k), gotovf, e.ovf);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_one(0, ov0, o0, of0, rdy0);
      mon_one(1, ov1, {4'd0, o1}, of1, rdy1);
      mon_one(2, ov2, o2, of2, rdy2);
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic send(bit f, bit l, logic [4:0] a, logic [6:0] b, logic [15:0] c);
    bit done = 1'b0;
    bit acc;
    int tries = 0;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    a_in     = a;
    b_in     = b;
    c_in     = c;
    while (!done) begin
      if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      if (acc) begin
        model_beat(f, l, a, b, c);
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", tries);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_in_ready"}, rdy0, 1);
    check({tag, "_out_valid"}, ov0, 0);
    check({tag, "_out"}, o0, 0);
    check({tag, "_out_ovf"}, of0, 0);
    check({tag, "_out_valid_w12"}, ov1, 0);
    check({tag, "_out_valid_sgn"}, ov2, 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Single-beat frames and two-cycle latency
    send(1'b1, 1'b1, 5'd13, 7'd23, 16'd1012);
    check("latency_early", ov0, 0);
    send(1'b1, 1'b1, 5'd15, 7'd21, 16'd598);
    check("latency_two_cycles", ov0, 1);
    idle(4);

    // Three-beat frame immediately followed by a one-beat frame
    send(1'b1, 1'b0, 5'd2, 7'd3, 16'd100);
    send(1'b0, 1'b0, 5'd4, 7'd5, 16'd0);
    send(1'b0, 1'b1, 5'd6, 7'd7, 16'd0);
    send(1'b1, 1'b1, 5'd1, 7'd1, 16'd0);
    idle(4);

    // Same frames with the output held off for four cycles
    out_ready = 1'b0;
    send(1'b1, 1'b0, 5'd2, 7'd3, 16'd100);
    send(1'b0, 1'b0, 5'd4, 7'd5, 16'd0);
    send(1'b0, 1'b1, 5'd6, 7'd7, 16'd0);
    send(1'b1, 1'b1, 5'd1, 7'd1, 16'd0);
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready_low", rdy0, 0);
      check("bp_out_valid_held", ov0, 1);
      idle(1);
    end
    out_ready = 1'b1;
    send(1'b1, 1'b1, 5'd2, 7'd2, 16'd5);
    idle(5);

    // Overflow: 31*127+4000 overflows 12 bits
    send(1'b1, 1'b1, 5'd31, 7'd127, 16'd4000);
    idle(4);

    // Signed: A=-3, B=-50, C=-200
    send(1'b1, 1'b1, 5'h1D, 7'h4E, 16'hFF38);
    idle(4);

    // Restart mid-frame, then a non-first beat after the close
    send(1'b1, 1'b0, 5'd1, 7'd1, 16'd10);
    send(1'b1, 1'b1, 5'd2, 7'd2, 16'd20);
    send(1'b0, 1'b1, 5'd3, 7'd3, 16'd0);
    idle(5);

    // Reset after two beats of a frame; a beat offered during reset is ignored
    send(1'b1, 1'b0, 5'd3, 7'd3, 16'd50);
    send(1'b0, 1'b0, 5'd4, 7'd4, 16'd0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    a_in     = 5'd7;
    b_in     = 7'd7;
    c_in     = 16'd7;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check_reset_state("midreset");
    idle(3);
    send(1'b1, 1'b1, 5'd1, 7'd2, 16'd5);
    idle(4);

    // Randomized frames with random backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           5'($urandom), 7'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    ready_rand = 1'b0;
    out_ready  = 1'b1;
    begin
      int n = 0;
      while ((q0.size() + q1.size() + q2.size()) > 0 && n < 100) begin
        idle(1);
        n++;
      end
    end
    idle(2);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("drain_q2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
